mdio_peripheral: RTL

Responder (PHY side) of the MDIO management interface; the counterpart to the MDIO controller that serialises 32-bit T_DATA frames onto MDC/MDIO_OUT.
- Samples controller-driven bits on MDC rising edges and decodes Clause-22 frames: ST(2) OP(2) PHYAD(5) REGAD(5) TA(2) DATA(16), MSB first, no preamble.
- Issues register write strobes and read requests to a local register file.
- On reads, serialises register data back to the controller on MDIO_IN.

---
 rtl/mdio_pkg.sv | 44 ++++
 rtl/mdio_peripheral_if.sv | 26 ++
 rtl/mdc_edge_detect.sv | 21 ++
 rtl/mdio_peripheral.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared MDIO frame definitions: FSM states, frame field codes and header layout.
package mdio_pkg;

  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned HDR_BITS   = 14;
  localparam int unsigned DATA_BITS  = 16;
  localparam int unsigned ADDR_BITS  = 5;
  localparam int unsigned CNT_BITS   = 6;

  // Bit indices (0-based rise count) where frame decisions are taken
  localparam int unsigned ST_LAST_BIT  = 1;
  localparam int unsigned OP_LAST_BIT  = 3;
  localparam int unsigned HDR_LAST_BIT = HDR_BITS - 1;
  localparam int unsigned TA_LAST_BIT  = 15;
  localparam int unsigned LAST_BIT     = FRAME_BITS - 1;

  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] TA_WRITE = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    TA,
    WRITE_DATA,
    READ_DATA,
    DISCARD
  } mdio_state_e;

  // Clause-22 header as it sits in the shift register, MSB first
  typedef struct packed {
    logic [1:0]           st;
    logic [1:0]           op;
    logic [ADDR_BITS-1:0] phyad;
    logic [ADDR_BITS-1:0] regad;
  } mdio_hdr_t;

  // Only write and read opcodes are supported
  function automatic logic op_supported(input logic [1:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/mdio_peripheral_if.sv
// MDIO management bus between controller (master) and PHY-side responder (slave).
interface mdio_peripheral_if;

  logic MDC;
  logic MDIO_OUT;
  logic MDIO_OE;
  logic MDIO_IN;
  logic MDIO_IN_OE;

  modport master (
    output MDC,
    output MDIO_OUT,
    output MDIO_OE,
    input  MDIO_IN,
    input  MDIO_IN_OE
  );

  modport slave (
    input  MDC,
    input  MDIO_OUT,
    input  MDIO_OE,
    output MDIO_IN,
    output MDIO_IN_OE
  );

endinterface

// File: rtl/mdc_edge_detect.sv
// Registers MDC in the clk domain and flags its rising and falling edges.
module mdc_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic mdc,
  output logic rise_c,
  output logic fall_c
);

  logic mdc_q;

  // Previous MDC value
  always_ff @(posedge clk) begin
    if (reset) mdc_q <= 1'b0;
    else       mdc_q <= mdc;
  end

  assign rise_c = mdc & ~mdc_q;
  assign fall_c = ~mdc & mdc_q;

endmodule

// File: rtl/mdio_peripheral.sv
// PHY-side MDIO responder: decodes Clause-22 frames, strobes the local
// register file and shifts read data back to the controller.
module mdio_peripheral
  import mdio_pkg::*;
#(
  parameter logic [ADDR_BITS-1:0] PHY_ADDR = 5'h18
) (
  input  logic                 clk,
  input  logic                 reset,
  mdio_peripheral_if.slave     mdio,
  output logic [ADDR_BITS-1:0] ADDR,
  output logic [DATA_BITS-1:0] WR_DATA,
  output logic                 WR_STB,
  output logic                 RD_REQ,
  input  logic [DATA_BITS-1:0] RD_DATA,
  output logic                 FRAME_ERR
);

  logic rise_c;
  logic fall_c;

  mdio_state_e          state;
  logic [CNT_BITS-1:0]  bit_cnt;
  logic [CNT_BITS-1:0]  cnt_inc;
  // The newest header/data bit comes straight from the line, so only the
  // older bits need storage.
  logic [HDR_BITS-2:0]  hdr;
  logic [HDR_BITS-1:0]  hdr_next;
  mdio_hdr_t            hdr_f;
  logic [DATA_BITS-2:0] rx;
  logic [DATA_BITS-1:0] rx_next;
  logic [DATA_BITS-1:0] tx;
  logic [3:0]           tx_idx;
  logic                 is_read;
  logic                 rd_pend;
  logic                 mdio_in_q;
  logic                 mdio_in_oe_q;

  mdc_edge_detect u_edge (
    .clk    (clk),
    .reset  (reset),
    .mdc    (mdio.MDC),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  // Shift candidates, saturating bit count and read-data bit selection
  always_comb begin
    cnt_inc  = (bit_cnt == CNT_BITS'(FRAME_BITS)) ? bit_cnt : bit_cnt + CNT_BITS'(1);
    hdr_next = {hdr, mdio.MDIO_OUT};
    hdr_f    = mdio_hdr_t'(hdr_next);
    rx_next  = {rx, mdio.MDIO_OUT};
    tx_idx   = 4'(5'(LAST_BIT) - bit_cnt[4:0]);
  end

  assign mdio.MDIO_IN    = mdio_in_q;
  assign mdio.MDIO_IN_OE = mdio_in_oe_q;

  // Frame FSM with registered strobes and MDIO_IN drive
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      hdr          <= '0;
      rx           <= '0;
      tx           <= '0;
      is_read      <= 1'b0;
      rd_pend      <= 1'b0;
      mdio_in_q    <= 1'b0;
      mdio_in_oe_q <= 1'b0;
      ADDR         <= '0;
      WR_DATA      <= '0;
      WR_STB       <= 1'b0;
      RD_REQ       <= 1'b0;
      FRAME_ERR    <= 1'b0;
    end else begin
      WR_STB    <= 1'b0;
      RD_REQ    <= 1'b0;
      FRAME_ERR <= 1'b0;

      // Register file answers one clk after RD_REQ
      rd_pend <= RD_REQ;
      if (rd_pend) tx <= RD_DATA;

      unique case (state)
        IDLE: begin
          if (rise_c && mdio.MDIO_OE) begin
            hdr     <= hdr_next[HDR_BITS-2:0];
            bit_cnt <= CNT_BITS'(1);
            state   <= HEADER;
          end
        end

        HEADER: begin
          if (rise_c) begin
            hdr     <= hdr_next[HDR_BITS-2:0];
            bit_cnt <= cnt_inc;
            if (bit_cnt == CNT_BITS'(ST_LAST_BIT)) begin
              if (hdr_next[1:0] != ST_CODE) begin
                state     <= DISCARD;
                FRAME_ERR <= 1'b1;
              end
            end else if (bit_cnt == CNT_BITS'(OP_LAST_BIT)) begin
              if (!op_supported(hdr_next[1:0])) begin
                state     <= DISCARD;
                FRAME_ERR <= 1'b1;
              end
              is_read <= (hdr_next[1:0] == OP_READ);
            end else if (bit_cnt == CNT_BITS'(HDR_LAST_BIT)) begin
              if ((hdr_f.phyad != PHY_ADDR) || (hdr_f.st != ST_CODE)) begin
                state     <= DISCARD;
                FRAME_ERR <= 1'b1;
              end else begin
                ADDR   <= hdr_f.regad;
                RD_REQ <= (hdr_f.op == OP_READ);
                state  <= TA;
              end
            end
          end
        end

        TA: begin
          if (rise_c) begin
            rx      <= rx_next[DATA_BITS-2:0];
            bit_cnt <= cnt_inc;
            if (bit_cnt == CNT_BITS'(TA_LAST_BIT)) begin
              if (is_read) begin
                state <= READ_DATA;
              end else if (rx_next[1:0] == TA_WRITE) begin
                state <= WRITE_DATA;
              end else begin
                state     <= DISCARD;
                FRAME_ERR <= 1'b1;
              end
            end
          end else if (fall_c && is_read && (bit_cnt == CNT_BITS'(TA_LAST_BIT))) begin
            // Second TA bit: take the line and hold it low
            mdio_in_oe_q <= 1'b1;
            mdio_in_q    <= 1'b0;
          end
        end

        WRITE_DATA: begin
          if (rise_c) begin
            rx <= rx_next[DATA_BITS-2:0];
            if (bit_cnt == CNT_BITS'(LAST_BIT)) begin
              WR_DATA <= rx_next;
              WR_STB  <= 1'b1;
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              bit_cnt <= cnt_inc;
            end
          end
        end

        READ_DATA: begin
          if (rise_c) begin
            bit_cnt <= cnt_inc;
          end else if (fall_c) begin
            if (bit_cnt == CNT_BITS'(FRAME_BITS)) begin
              mdio_in_oe_q <= 1'b0;
              mdio_in_q    <= 1'b0;
              bit_cnt      <= '0;
              state        <= IDLE;
            end else if (bit_cnt > CNT_BITS'(TA_LAST_BIT)) begin
              mdio_in_q <= tx[tx_idx];
            end
          end
        end

        DISCARD: begin
          if (rise_c) begin
            if (!mdio.MDIO_OE || (bit_cnt == CNT_BITS'(LAST_BIT))) begin
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              bit_cnt <= cnt_inc;
            end
          end
        end

        default: begin
          bit_cnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
